// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 key encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] c_PFX_E0 = 8'hE0;
    localparam logic [7:0] c_PFX_F0 = 8'hF0;
    localparam logic [7:0] c_PFX_E1 = 8'hE1;

    localparam int c_KEY_TOGGLE  = 10;
    localparam int c_KEY_PRESSED = 9;
    localparam int c_KEY_EXT     = 8;

    // Keyboard status/response bytes that never represent a key.
    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : 2-flop synchronizer, glitch filter and falling-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    localparam int                CNT_W   = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(FILTER - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // The level flips on the FILTER-th consecutive sample that disagrees with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_key_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_encoder
// Description : PS/2 frame receiver and scancode-to-toggle-word encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 24576
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESETn,
    input  logic        I_PS2_CLK,
    input  logic        I_PS2_DAT,
    output logic [10:0] O_PS2_KEY,
    output logic        O_FRAME_ERR
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] c_TO_MAX = TO_W'(TIMEOUT);

    logic w_fall;
    logic w_dat;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
        .i_clk   (I_CLK_24576M),
        .i_rst_n (I_RESETn),
        .i_pin   (I_PS2_CLK),
        .o_level (),
        .o_fall  (w_fall)
    );

    // Data edges carry no meaning; only the filtered level is sampled.
    ps2_line_filter #(.FILTER(FILTER)) u_dat_filt (
        .i_clk   (I_CLK_24576M),
        .i_rst_n (I_RESETn),
        .i_pin   (I_PS2_DAT),
        .o_level (w_dat),
        .o_fall  ()
    );

    frame_state_t    r_state, w_state_nxt;
    logic [2:0]      r_bitcnt, w_bitcnt_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_par, w_par_nxt;
    logic [TO_W-1:0] r_tocnt;
    logic            w_vld, w_err;
    logic            r_vld, r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_vld        = 1'b0;
        w_err        = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_dat) begin
                        w_state_nxt  = ST_DATA;
                        w_bitcnt_nxt = 3'd0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt  = {w_dat, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7)
                        w_state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    w_par_nxt   = w_dat;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_dat && (^{r_shift, r_par}))
                        w_vld = 1'b1;
                    else
                        w_err = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if ((r_state != ST_IDLE) && (r_tocnt == c_TO_MAX)) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_par    <= 1'b0;
            r_tocnt  <= '0;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_vld    <= w_vld;
            r_err    <= w_err;
            if (w_fall)
                r_tocnt <= '0;
            else if (r_tocnt != c_TO_MAX)
                r_tocnt <= r_tocnt + 1'b1;
        end
    end

    logic [10:0] r_key;
    logic        r_frame_err;
    logic        r_ext, r_brk;
    logic [2:0]  r_skip;

    // r_shift is stable for the cycle after the stop bit, so it doubles as the byte register.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_key       <= 11'd0;
            r_frame_err <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_skip      <= 3'd0;
        end else begin
            r_frame_err <= r_err;
            if (r_vld) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else if (r_shift == c_PFX_E1) begin
                    r_skip <= 3'd7;
                end else if (r_shift == c_PFX_E0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == c_PFX_F0) begin
                    r_brk <= 1'b1;
                end else if (is_discard(r_shift)) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end else begin
                    r_key[c_KEY_TOGGLE]  <= ~r_key[c_KEY_TOGGLE];
                    r_key[c_KEY_PRESSED] <= ~r_brk;
                    r_key[c_KEY_EXT]     <= r_ext;
                    r_key[7:0]           <= r_shift;
                    r_ext                <= 1'b0;
                    r_brk                <= 1'b0;
                end
            end
        end
    end

    assign O_PS2_KEY   = r_key;
    assign O_FRAME_ERR = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_encoder
// Description : Directed self-checking bench for ps2_key_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_key_encoder;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 24576;
    localparam int HALF    = 20;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] key;
    logic        ferr;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int err_hi = 0;
    int tog_chg = 0;
    int lat;
    int elat;
    logic prev_err = 1'b0;
    logic prev_tog = 1'b0;

    ps2_key_encoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .I_CLK_24576M (clk),
        .I_RESETn     (rst_n),
        .I_PS2_CLK    (ps2_clk),
        .I_PS2_DAT    (ps2_dat),
        .O_PS2_KEY    (key),
        .O_FRAME_ERR  (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) err_hi = err_hi + 1;
        if (ferr && !prev_err) err_pulses = err_pulses + 1;
        if (key[10] !== prev_tog) tog_chg = tog_chg + 1;
        prev_err = ferr;
        prev_tog = key[10];
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half period.
    task automatic ps2_bit(input logic b, input bit measure);
        logic [10:0] k0;
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        if (measure) begin
            k0   = key;
            lat  = 0;
            elat = 0;
            for (int i = 1; i <= HALF; i++) begin
                @(negedge clk);
                if (lat == 0 && key !== k0) lat = i;
                if (elat == 0 && ferr) elat = i;
            end
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(bad_par ? (^b) : ~(^b), 1'b0);
        ps2_bit(~bad_stop, 1'b1);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
        wait_cyc(5);
        checks++;
        if (key !== 11'h000) begin errors++; $display("FAIL reset_key: got %h expected %h", key, 11'h000); end
        checks++;
        if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ferr); end
        rst_n = 1'b1;
        wait_cyc(30);
    endtask

    task automatic test_make_code();
        int p0 = err_pulses;
        send_byte(8'h1C, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h61C) begin errors++; $display("FAIL make_1c: got %h expected %h", key, 11'h61C); end
        checks++;
        if (lat !== FILTER + 4) begin errors++; $display("FAIL make_latency: got %0d expected %0d", lat, FILTER + 4); end
        checks++;
        if (err_pulses - p0 !== 0) begin errors++; $display("FAIL make_noerr: got %0d expected 0", err_pulses - p0); end
    endtask

    task automatic test_ext_release();
        int t0 = tog_chg;
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h175) begin errors++; $display("FAIL ext_release: got %h expected %h", key, 11'h175); end
        checks++;
        if (tog_chg - t0 !== 1) begin errors++; $display("FAIL ext_toggles: got %0d expected 1", tog_chg - t0); end
    endtask

    task automatic test_parity_error();
        int p0 = err_pulses;
        int h0 = err_hi;
        send_byte(8'h29, 1'b1, 1'b0);
        checks++;
        if (err_pulses - p0 !== 1) begin errors++; $display("FAIL par_pulses: got %0d expected 1", err_pulses - p0); end
        checks++;
        if (err_hi - h0 !== 1) begin errors++; $display("FAIL par_width: got %0d expected 1", err_hi - h0); end
        checks++;
        if (elat !== FILTER + 4) begin errors++; $display("FAIL par_latency: got %0d expected %0d", elat, FILTER + 4); end
        checks++;
        if (key !== 11'h175) begin errors++; $display("FAIL par_hold: got %h expected %h", key, 11'h175); end
        send_byte(8'h29, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h629) begin errors++; $display("FAIL par_next: got %h expected %h", key, 11'h629); end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        int t0 = tog_chg;
        for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0, 1'b0);
        checks++;
        if (tog_chg - t0 !== 0) begin errors++; $display("FAIL pause_silent: got %0d expected 0", tog_chg - t0); end
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h16, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h216) begin errors++; $display("FAIL pause_after: got %h expected %h", key, 11'h216); end
        checks++;
        if (tog_chg - t0 !== 1) begin errors++; $display("FAIL pause_toggles: got %0d expected 1", tog_chg - t0); end
    endtask

    task automatic test_timeout();
        int p0 = err_pulses;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        ps2_dat = 1'b1;
        wait_cyc(TIMEOUT - 100);
        checks++;
        if (err_pulses - p0 !== 0) begin errors++; $display("FAIL to_early: got %0d expected 0", err_pulses - p0); end
        wait_cyc(300);
        checks++;
        if (err_pulses - p0 !== 1) begin errors++; $display("FAIL to_pulse: got %0d expected 1", err_pulses - p0); end
        send_byte(8'h1C, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h61C) begin errors++; $display("FAIL to_recover: got %h expected %h", key, 11'h61C); end
    endtask

    task automatic test_glitch();
        int p0 = err_pulses;
        int t0 = tog_chg;
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(HALF);
        end
        checks++;
        if (err_pulses - p0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_pulses - p0); end
        checks++;
        if (tog_chg - t0 !== 0) begin errors++; $display("FAIL glitch_key: got %0d expected 0", tog_chg - t0); end
        send_byte(8'h16, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h216) begin errors++; $display("FAIL glitch_next: got %h expected %h", key, 11'h216); end
    endtask

    task automatic test_errors_keep_prefix();
        int p0 = err_pulses;
        send_byte(8'h33, 1'b0, 1'b1);
        checks++;
        if (err_pulses - p0 !== 1) begin errors++; $display("FAIL stop_err: got %0d expected 1", err_pulses - p0); end
        ps2_bit(1'b1, 1'b0);
        wait_cyc(HALF);
        checks++;
        if (err_pulses - p0 !== 2) begin errors++; $display("FAIL start_err: got %0d expected 2", err_pulses - p0); end
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h43C) begin errors++; $display("FAIL prefix_persist: got %h expected %h", key, 11'h43C); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (key !== 11'h000) begin errors++; $display("FAIL rst_async_key: got %h expected %h", key, 11'h000); end
        wait_cyc(3);
        ps2_dat = 1'b1;
        ps2_clk = 1'b1;
        rst_n = 1'b1;
        wait_cyc(30);
        send_byte(8'h1C, 1'b0, 1'b0);
        checks++;
        if (key !== 11'h61C) begin errors++; $display("FAIL rst_clears_ext: got %h expected %h", key, 11'h61C); end
    endtask

    initial begin
        test_reset();
        test_make_code();
        test_ext_release();
        test_parity_error();
        test_pause();
        test_timeout();
        test_glitch();
        test_errors_keep_prefix();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Front-end that samples a raw PS/2 keyboard line and emits key events in the 11-bit toggle-word format the core's key decoder consumes. Bit 10 toggles once per event; bit 9 is pressed; bit 8 is the extended (E0) flag; bits 7:0 are the scancode. It sits between the board's PS/2 pins (or user-port pins) and the top-level key-decode logic, and is used wherever the HPS key path is unavailable.

## Interface
- FILTER, 8: number of consecutive identical synchronized samples required before the filtered PS/2 clock or data level changes.
- TIMEOUT, 24576: idle cycles allowed between falling clock edges inside a frame before the frame is discarded (1 ms at 24.576 MHz).
- I_CLK_24576M  in  1  system clock; the only clock.
- I_RESETn  in  1  reset; asynchronous, active-low.
- I_PS2_CLK  in  1  raw PS/2 clock, asynchronous to the system clock.
- I_PS2_DAT  in  1  raw PS/2 data, asynchronous to the system clock.
- O_PS2_KEY  out  11  event word {toggle, pressed, ext, code[7:0]}.
- O_FRAME_ERR  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Input path: a 2-flop synchronizer on each pin feeds a glitch filter. The filtered level changes only after FILTER equal samples. A filtered clock falling edge produces a one-cycle strobe `fall`.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data = 0 (start bit), go to DATA and clear the bit count. On `fall` with data = 1, stay in IDLE and pulse O_FRAME_ERR.
  - DATA: shift data in LSB first on each `fall`. After the 8th bit, go to PARITY.
  - PARITY: capture the bit. Odd parity over the 8 data bits plus the parity bit is required. Go to STOP.
  - STOP: on `fall`, the byte is valid only if stop = 1 and parity is good. Otherwise pulse O_FRAME_ERR and drop the byte. Go to IDLE in both cases.
- Timeout: a counter clears on every `fall`. If it reaches TIMEOUT while the FSM is not in IDLE, the FSM returns to IDLE and O_FRAME_ERR pulses. The counter saturates and does not wrap.
- Byte layer, applied to valid bytes, with flags `ext`, `brk` and a 3-bit `skip`:
  - If skip ≠ 0: decrement skip and drop the byte.
  - E1: set skip = 7. Pause sequences emit nothing.
  - E0: set ext.
  - F0: set brk.
  - 00, AA, EE, FA, FC, FD, FE, FF: drop the byte and clear ext and brk.
  - Any other byte: update O_PS2_KEY to {~O_PS2_KEY[10], ~brk, ext, byte}, then clear ext and brk.
- Prefix flags persist across frame errors. They clear only on a completed code or on reset.
- Reset values: O_PS2_KEY = 0, O_FRAME_ERR = 0, FSM in IDLE, ext = brk = 0, skip = 0, filtered levels = 1, timeout counter = 0.
- Reset asserted mid-frame discards the partial byte. No event is emitted.

## Timing
- `fall` is asserted in cycle E, which occurs 2 + FILTER cycles after the raw edge when the pin is clean.
- For the stop-bit `fall` in cycle E, O_PS2_KEY and O_FRAME_ERR change at the clock edge that ends cycle E+1. This is a fixed 1-cycle decode register.
- At most one event is produced per frame. The minimum frame spacing (≥ 60 µs) far exceeds the pipeline, so no buffering is required.
- A timeout and a `fall` in the same cycle: `fall` wins and the counter clears.
- O_PS2_KEY holds its value between events. Consumers detect a new event only by the change of bit 10.

## Structure
- Shared package `ps2_pkg` holds:
  - the frame FSM state enum;
  - the prefix constants E0, F0, E1;
  - the discard list;
  - the event-word field positions (TOGGLE = 10, PRESSED = 9, EXT = 8).
- Sub-module `ps2_line_filter` (synchronizer, glitch filter and edge strobe) is instantiated twice, once for clock and once for data. Only the clock instance uses the edge strobe.

## Test plan
- Make code 1C (odd parity), sent as a clean frame from reset → O_PS2_KEY = 11'h61C two cycles after the stop `fall`; no O_FRAME_ERR.
- Sequence E0 F0 75 (extended up release), following one prior event → O_PS2_KEY = {prior toggle inverted, 0, 1, 8'h75}; a single toggle only.
- Byte 29 sent with wrong parity → O_FRAME_ERR pulses for exactly 1 cycle; O_PS2_KEY unchanged. The next valid 29 → toggle inverts and the word reads 0x229 with the toggle set accordingly.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 16 → no event during the pause; a single event {t, 1, 0, 8'h16} afterward.
- Clock stopped after 4 data bits for more than TIMEOUT cycles → O_FRAME_ERR pulse; the FSM is back in IDLE; the following full frame decodes correctly.
- 3-cycle glitch pulses on I_PS2_CLK with FILTER = 8 → no `fall` and no state change. Reset asserted mid-frame → all outputs return to 0 asynchronously.
